// File: rtl/dbus_pkg.sv
// Request/response types shared by the pipeline memory stage and the data-bus responder.
package dbus_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder.sv
// Single-outstanding data-bus responder backed by a word-addressed 64-bit SRAM.
// Responds LATENCY cycles after acceptance with byte-strobe write merge and alignment check.
module dbus_sram_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  dbus_pkg::dbus_req_t   dreq,
  output dbus_pkg::dbus_resp_t  dresp,
  output logic                  misalign
);
  import dbus_pkg::*;

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic f_misaligned(input msize_t size, input logic [2:0] lo);
    case (size)
      MSIZE2:  f_misaligned = (lo[0] != 1'b0);
      MSIZE4:  f_misaligned = (lo[1:0] != 2'b00);
      MSIZE8:  f_misaligned = (lo != 3'b000);
      default: f_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] f_merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] strobe);
    f_merge = old_w;
    for (int i = 0; i < 8; i++) begin
      if (strobe[i]) f_merge[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          w_accept, w_fire;

  logic [AW+2:0] r_addr;
  msize_t        r_size;
  logic [7:0]    r_strobe;
  logic [63:0]   r_wdata;

  logic [63:0]   r_mem [DEPTH];

  logic          r_addr_ok, r_data_ok, r_misalign;
  logic [63:0]   r_rdata;

  logic          w_use_in;
  logic [AW+2:0] w_addr;
  msize_t        w_size;
  logic [7:0]    w_strobe;
  logic [63:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_merged;
  logic          w_mis;
  logic          w_unused;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dreq.valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 4'(LATENCY - 1);
          w_state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (w_cnt_nxt == 4'd0) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The access happens on the edge entering RESP; with LATENCY=1 that is the
  // accepting edge itself, so the live request is used instead of the latched copy.
  assign w_fire   = (w_state_nxt == S_RESP);
  assign w_use_in = (r_state == S_IDLE);
  assign w_addr   = w_use_in ? dreq.addr[AW+2:0] : r_addr;
  assign w_size   = w_use_in ? dreq.size         : r_size;
  assign w_strobe = w_use_in ? dreq.strobe       : r_strobe;
  assign w_wdata  = w_use_in ? dreq.data         : r_wdata;
  assign w_idx    = w_addr[AW+2:3];
  assign w_mis    = f_misaligned(w_size, w_addr[2:0]);
  assign w_merged = f_merge(r_mem[w_idx], w_wdata, w_strobe);
  assign w_unused = ^dreq.addr[63:AW+3];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr   <= dreq.addr[AW+2:0];
      r_size   <= dreq.size;
      r_strobe <= dreq.strobe;
      r_wdata  <= dreq.data;
    end
  end

  // Reset blocks a pending commit but never clears stored contents.
  always_ff @(posedge clk) begin
    if (resetn && w_fire && !w_mis && (w_strobe != 8'h00)) r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr_ok  <= 1'b0;
      r_data_ok  <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata    <= 64'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr_ok  <= w_fire;
      r_data_ok  <= w_fire;
      r_misalign <= w_fire && w_mis;
      r_rdata    <= (w_fire && !w_mis) ? w_merged : 64'd0;
    end
  end

  assign dresp.addr_ok = r_addr_ok;
  assign dresp.data_ok = r_data_ok;
  assign dresp.data    = r_rdata;
  assign misalign      = r_misalign;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and
// randomized traffic against a transaction-level memory model.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int DEPTH = 512;
  localparam int L     = 2;

  logic       clk = 1'b0;
  logic       resetn;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       misalign;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  dbus_sram_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .dreq     (dreq),
    .dresp    (dresp),
    .misalign (misalign)
  );

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_mis;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, " flags"}, {61'd0, dresp.addr_ok, dresp.data_ok, misalign}, 64'd0);
    chk({name, " data"}, dresp.data, 64'd0);
  endtask

  // Reference: a request of 2**size bytes is misaligned when addr is not a multiple of that size.
  task automatic model(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                       input logic [63:0] d, output logic [63:0] e, output logic m);
    int idx;
    longint unsigned nb;
    idx = int'((a / 8) % DEPTH);
    nb  = 64'd1 << sz;
    m   = ((a % nb) != 0);
    if (m) begin
      e = 64'd0;
    end else begin
      e = mem_m[idx];
      for (int b = 0; b < 8; b++)
        if (st[b]) e[8*b +: 8] = d[8*b +: 8];
      mem_m[idx] = e;
    end
  endtask

  // Issue one request in the current cycle, then scramble the bus and drop valid
  // during WAIT; returns in the first idle cycle after the response.
  task automatic do_req(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                        input logic [63:0] d, input logic [63:0] exp_d, input logic exp_m,
                        input string name);
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = msize_t'(sz);
    dreq.strobe = st;
    dreq.data   = d;
    tick;
    dreq.valid  = 1'b0;
    dreq.addr   = {$urandom, $urandom};
    dreq.size   = msize_t'($urandom_range(0, 3));
    dreq.strobe = 8'($urandom);
    dreq.data   = {$urandom, $urandom};
    for (int k = 1; k < L; k++) begin
      chk_quiet({name, " wait"});
      tick;
    end
    chk({name, " ok"}, {62'd0, dresp.addr_ok, dresp.data_ok}, 64'd3);
    chk({name, " data"}, dresp.data, exp_d);
    chk({name, " misalign"}, {63'd0, misalign}, {63'd0, exp_m});
    tick;
    chk_quiet({name, " after"});
  endtask

  vec_t vecs [$];

  initial begin
    logic [63:0] e;
    logic        m;
    int          npulse;

    vecs.push_back('{64'h10,   3'd3, 8'hFF, 64'h1122334455667788, 64'h1122334455667788, 1'b0, "sd_10"});
    vecs.push_back('{64'h10,   3'd3, 8'h00, 64'h0,                64'h1122334455667788, 1'b0, "ld_10"});
    vecs.push_back('{64'h15,   3'd0, 8'h20, 64'h0000AA0000000000, 64'h1122AA4455667788, 1'b0, "sb_15"});
    vecs.push_back('{64'h10,   3'd3, 8'h00, 64'h0,                64'h1122AA4455667788, 1'b0, "ld_merge"});
    vecs.push_back('{64'h12,   3'd2, 8'h3C, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1, "sw_mis"});
    vecs.push_back('{64'h10,   3'd3, 8'h00, 64'h0,                64'h1122AA4455667788, 1'b0, "ld_after_mis"});
    vecs.push_back('{64'h13,   3'd0, 8'h00, 64'h0,                64'h1122AA4455667788, 1'b0, "lb_13"});
    vecs.push_back('{64'h16,   3'd1, 8'h00, 64'h0,                64'h1122AA4455667788, 1'b0, "lh_16"});
    vecs.push_back('{64'h17,   3'd1, 8'h00, 64'h0,                64'h0,                1'b1, "lh_17_mis"});
    vecs.push_back('{64'h1010, 3'd3, 8'h00, 64'h0,                64'h1122AA4455667788, 1'b0, "ld_alias"});
    vecs.push_back('{64'h20,   3'd3, 8'hFF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0, "sd_20"});
    vecs.push_back('{64'h24,   3'd3, 8'hFF, 64'h5555555555555555, 64'h0,                1'b1, "sd_mis"});
    vecs.push_back('{64'h26,   3'd1, 8'hC0, 64'hFFFF000000000000, 64'hFFFF456789ABCDEF, 1'b0, "sh_26"});
    vecs.push_back('{64'h20,   3'd3, 8'h00, 64'h0,                64'hFFFF456789ABCDEF, 1'b0, "ld_20"});

    // Reset held with a valid write pending on the bus.
    resetn      = 1'b0;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h30;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hCAFEF00DDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_quiet("reset hold");
    end
    resetn = 1'b1;
    model(64'h30, 3'd3, 8'hFF, 64'hCAFEF00DDEADBEEF, e, m);
    tick;
    dreq.valid = 1'b0;
    for (int k = 1; k < L; k++) begin
      chk_quiet("post reset wait");
      tick;
    end
    chk("post reset ok", {62'd0, dresp.addr_ok, dresp.data_ok}, 64'd3);
    chk("post reset data", dresp.data, 64'hCAFEF00DDEADBEEF);
    tick;
    chk_quiet("post reset after");

    foreach (vecs[i]) begin
      model(vecs[i].addr, vecs[i].size, vecs[i].strobe, vecs[i].data, e, m);
      do_req(vecs[i].addr, vecs[i].size, vecs[i].strobe, vecs[i].data,
             vecs[i].exp_data, vecs[i].exp_mis, vecs[i].name);
    end

    // Reset during WAIT of a write: it must never respond nor commit.
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h20;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hDEADDEADDEADDEAD;
    tick;
    dreq.valid = 1'b0;
    resetn     = 1'b0;
    tick;
    chk_quiet("rst mid wait");
    resetn = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      chk_quiet("rst no resp");
      tick;
    end
    do_req(64'h20, 3'd3, 8'h00, 64'h0, 64'hFFFF456789ABCDEF, 1'b0, "ld_20_after_rst");

    // Held request: one serve per LATENCY+1 cycles, no re-accept during RESP.
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h30;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    npulse = 0;
    for (int c = 0; c < 3 * (L + 1) + 3; c++) begin
      if (c == 2 * (L + 1) + 1) dreq.valid = 1'b0;
      if (dresp.data_ok === 1'b1) begin
        chk("b2b pulse cycle", 64'(c), 64'((npulse + 1) * (L + 1) - 1));
        chk("b2b data", dresp.data, mem_m[6]);
        npulse++;
      end
      tick;
    end
    chk("b2b pulse count", 64'(npulse), 64'd3);

    for (int w = 8; w < 16; w++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      model(64'(w * 8), 3'd3, 8'hFF, d, e, m);
      do_req(64'(w * 8), 3'd3, 8'hFF, d, e, m, "rand_init");
    end

    for (int n = 0; n < 60; n++) begin
      logic [63:0] a, d;
      logic [2:0]  sz;
      logic [7:0]  st;
      int          gap;
      a       = {$urandom, $urandom};
      a[11:3] = 9'(8 + $urandom_range(0, 7));
      sz      = 3'($urandom_range(0, 3));
      st      = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      d       = {$urandom, $urandom};
      model(a, sz, st, d, e, m);
      do_req(a, sz, st, d, e, m, "rand");
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick;
        chk_quiet("rand gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
